// File: rtl/mult_fu.sv
// mult_fu: single-issue, multi-cycle 8-bit multiply unit for the out-of-order core.
// Computes the low 8 bits of depvals[0] * depvals[1] by shift-add over eight
// cycles, then broadcasts the result on the CDB and writes the ROB in the same
// cycle once neither bus is claimed by another unit.
module mult_fu (
    input  logic            clk,
    input  logic            rst,
    input  logic            input_transmit,
    input  logic [7:0]      operand,
    input  logic [1:0][7:0] depvals,
    input  logic [7:0]      wbs,
    input  logic [7:0]      flags,
    input  logic [3:0]      robid,
    input  logic            cdb_transmit,
    output logic            cdb_transmit_out,
    output logic [3:0]      cdb_id,
    output logic [7:0]      cdb_val,
    input  logic            rob_transmit,
    output logic [3:0]      robid_out,
    output logic [7:0]      flags_out,
    output logic [7:0]      wbs_out,
    output logic [7:0]      value_out,
    output logic            rob_transmit_out,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPUTE   = 2'd1,
        S_BROADCAST = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_a;       // multiplicand, shifted left each iteration
    logic [7:0]  r_b;       // multiplier, shifted right each iteration
    logic [7:0]  r_acc;     // running partial product (mod 256)
    logic [2:0]  r_cnt;     // iteration counter, 0..7
    logic [7:0]  r_result;
    logic [3:0]  r_robid;
    logic [7:0]  r_wbs;
    logic [7:0]  r_flags;

    logic [7:0]  w_acc_next;
    logic        w_last_iter;
    logic        w_grant;

    // The opcode field carries nothing this unit needs.
    logic        w_unused_operand;
    assign w_unused_operand = ^operand;

    assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_last_iter = (r_cnt == 3'd7);
    assign w_grant     = (r_state == S_BROADCAST) && !cdb_transmit && !rob_transmit;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, leave COMPUTE after the 8th step,
    // leave BROADCAST only in a granted cycle.
    // NOTE: the default assigned first keeps every path driven, so no latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (input_transmit) w_next_state = S_COMPUTE;
            S_COMPUTE:   if (w_last_iter)    w_next_state = S_BROADCAST;
            S_BROADCAST: if (w_grant)        w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the instruction on accept, iterate shift-add in COMPUTE,
    // capture the result on the final iteration. BROADCAST holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_robid  <= '0;
            r_wbs    <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (input_transmit) begin
                        r_a     <= depvals[0];
                        r_b     <= depvals[1];
                        r_robid <= robid;
                        r_wbs   <= wbs;
                        r_flags <= flags;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_iter) begin
                        r_result <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: data straight from registers, strobes only on grant.
    assign busy             = (r_state != S_IDLE);
    assign cdb_transmit_out = w_grant;
    assign rob_transmit_out = w_grant;
    assign cdb_val          = r_result;
    assign value_out        = r_result;
    assign cdb_id           = r_robid;
    assign robid_out        = r_robid;
    assign wbs_out          = r_wbs;
    assign flags_out        = r_flags;

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: table-driven bench for mult_fu with a result scoreboard.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mult_fu;

    logic            clk;
    logic            rst;
    logic            input_transmit;
    logic [7:0]      operand;
    logic [1:0][7:0] depvals;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
    logic            cdb_transmit;
    logic            cdb_transmit_out;
    logic [3:0]      cdb_id;
    logic [7:0]      cdb_val;
    logic            rob_transmit;
    logic [3:0]      robid_out;
    logic [7:0]      flags_out;
    logic [7:0]      wbs_out;
    logic [7:0]      value_out;
    logic            rob_transmit_out;
    logic            busy;

    mult_fu dut (
        .clk              (clk),
        .rst              (rst),
        .input_transmit   (input_transmit),
        .operand          (operand),
        .depvals          (depvals),
        .wbs              (wbs),
        .flags            (flags),
        .robid            (robid),
        .cdb_transmit     (cdb_transmit),
        .cdb_transmit_out (cdb_transmit_out),
        .cdb_id           (cdb_id),
        .cdb_val          (cdb_val),
        .rob_transmit     (rob_transmit),
        .robid_out        (robid_out),
        .flags_out        (flags_out),
        .wbs_out          (wbs_out),
        .value_out        (value_out),
        .rob_transmit_out (rob_transmit_out),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] id;
        logic [7:0] wbs;
        logic [7:0] flags;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];
    vec_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction and follow it to its broadcast. cdb_hold/rob_hold
    // keep that bus claimed for the first N broadcast cycles (use one at a time).
    // intrude pulses a second issue mid-COMPUTE that must be ignored.
    task automatic run_op(input vec_t v, input int cdb_hold, input int rob_hold, input bit intrude);
        int   c;
        int   exp_cyc;
        bit   done;
        vec_t e;
        exp_cyc = 9 + cdb_hold + rob_hold;
        @(negedge clk);
        depvals[0]     = v.a;
        depvals[1]     = v.b;
        robid          = v.id;
        wbs            = v.wbs;
        flags          = v.flags;
        operand        = 8'hA5;
        input_transmit = 1'b1;
        sb.push_back(v);
        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) input_transmit = 1'b0;
            if (intrude && c == 3) begin
                depvals[0]     = 8'd13;
                depvals[1]     = 8'd11;
                robid          = ~v.id;
                wbs            = ~v.wbs;
                flags          = ~v.flags;
                input_transmit = 1'b1;
            end
            if (intrude && c == 4) input_transmit = 1'b0;
            cdb_transmit = (cdb_hold > 0) && (c < 9 + cdb_hold);
            rob_transmit = (rob_hold > 0) && (c < 9 + rob_hold);
            #1;
            if (c == 1) check("busy_after_accept", busy, 1);
            if (cdb_transmit_out || rob_transmit_out) begin
                done = 1'b1;
                check("strobe_cycle", c, exp_cyc);
                check("cdb_strobe", cdb_transmit_out, 1);
                check("rob_strobe", rob_transmit_out, 1);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("cdb_val", cdb_val, e.exp);
                    check("value_out", value_out, e.exp);
                    check("cdb_id", cdb_id, e.id);
                    check("robid_out", robid_out, e.id);
                    check("wbs_out", wbs_out, e.wbs);
                    check("flags_out", flags_out, e.flags);
                end
            end else if (c >= 9) begin
                check("held_value", value_out, v.exp);
                check("held_id", cdb_id, v.id);
                check("held_busy", busy, 1);
            end
        end
        if (!done) check("strobe_timeout", 0, 1);
        cdb_transmit = 1'b0;
        rob_transmit = 1'b0;
        @(negedge clk);
        #1;
        check("busy_after_bcast", busy, 0);
        check("strobe_after_bcast", cdb_transmit_out | rob_transmit_out, 0);
    endtask

    initial begin
        vecs[0] = '{a: 8'd5,   b: 8'd10,  id: 4'd1, wbs: 8'hB1, flags: 8'h11, exp: 8'd50};
        vecs[1] = '{a: 8'd7,   b: 8'd8,   id: 4'd2, wbs: 8'hB2, flags: 8'h22, exp: 8'd56};
        vecs[2] = '{a: 8'd25,  b: 8'd10,  id: 4'd3, wbs: 8'hB3, flags: 8'h33, exp: 8'd250};
        vecs[3] = '{a: 8'd1,   b: 8'd1,   id: 4'd4, wbs: 8'hB4, flags: 8'h44, exp: 8'd1};
        vecs[4] = '{a: 8'd16,  b: 8'd16,  id: 4'd5, wbs: 8'hC5, flags: 8'h55, exp: 8'd0};
        vecs[5] = '{a: 8'd255, b: 8'd255, id: 4'd6, wbs: 8'hC6, flags: 8'h66, exp: 8'd1};
        vecs[6] = '{a: 8'd0,   b: 8'd200, id: 4'd7, wbs: 8'hC7, flags: 8'h77, exp: 8'd0};
        vecs[7] = '{a: 8'd13,  b: 8'd11,  id: 4'd8, wbs: 8'hD8, flags: 8'h88, exp: 8'd143};
        vecs[8] = '{a: 8'd200, b: 8'd3,   id: 4'd9, wbs: 8'hD9, flags: 8'h99, exp: 8'd88};
        vecs[9] = '{a: 8'd6,   b: 8'd9,   id: 4'hE, wbs: 8'hDE, flags: 8'hEE, exp: 8'd54};

        rst            = 1'b1;
        input_transmit = 1'b0;
        operand        = '0;
        depvals        = '0;
        wbs            = '0;
        flags          = '0;
        robid          = '0;
        cdb_transmit   = 1'b0;
        rob_transmit   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", cdb_transmit_out | rob_transmit_out, 0);
        check("rst_value", value_out, 0);
        check("rst_cdb_id", cdb_id, 0);
        check("rst_wbs", wbs_out, 0);
        check("rst_flags", flags_out, 0);
        rst = 1'b0;

        // Plain table, including the overflow cases.
        for (int i = 0; i < 9; i++) run_op(vecs[i], 0, 0, 1'b0);

        // CDB held busy for three broadcast cycles, then ROB likewise.
        run_op(vecs[1], 3, 0, 1'b0);
        run_op(vecs[2], 0, 3, 1'b0);

        // Second issue while busy must be dropped.
        run_op(vecs[9], 0, 0, 1'b1);

        // Reset in the middle of COMPUTE drops the instruction.
        @(negedge clk);
        depvals[0]     = 8'd9;
        depvals[1]     = 8'd9;
        robid          = 4'd10;
        input_transmit = 1'b1;
        @(negedge clk);
        input_transmit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_strobes", cdb_transmit_out | rob_transmit_out, 0);
        check("midrst_value", value_out, 0);
        check("midrst_id", robid_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op('{a: 8'd3, b: 8'd4, id: 4'd11, wbs: 8'hEB, flags: 8'h0B, exp: 8'd12}, 0, 0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_fu.md
# mult_fu

Multi-cycle 8-bit integer multiply functional unit for the out-of-order core. It accepts one issued instruction with both source operands resolved and computes the low 8 bits of their product by iterative shift-add. It then broadcasts the result on the common data bus (CDB) and writes it to the reorder buffer (ROB) in the same cycle. Only one instruction is in flight at a time; `busy` tells the issue stage when the unit can take another.

## Interface
Parameters: none (widths fixed: data 8, ROB id 4).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `input_transmit`  in  1  issue strobe; instruction valid this cycle
- `operand`  in  8  opcode/operand field; ignored by this unit
- `depvals`  in  16 (packed [1:0][7:0])  source values; `depvals[0]`=bits[7:0], `depvals[1]`=bits[15:8]
- `wbs`  in  8  writeback-destination tag, carried to ROB
- `flags`  in  8  instruction flags, carried to ROB unchanged
- `robid`  in  4  ROB entry id of the instruction
- `cdb_transmit`  in  1  CDB occupied by another unit this cycle
- `cdb_transmit_out`  out  1  this unit drives the CDB this cycle
- `cdb_id`  out  4  ROB id tag on CDB
- `cdb_val`  out  8  result value on CDB
- `rob_transmit`  in  1  ROB write port occupied by another unit this cycle
- `robid_out`  out  4  ROB entry being written
- `flags_out`  out  8  flags written to ROB
- `wbs_out`  out  8  writeback tag written to ROB
- `value_out`  out  8  result written to ROB
- `rob_transmit_out`  out  1  this unit writes the ROB this cycle
- `busy`  out  1  unit holds an instruction; new issue not accepted

## Operation
- States: IDLE, COMPUTE, BROADCAST. `busy` = (state != IDLE).
- IDLE, `input_transmit`=1 at a clock edge:
  - latch `depvals[0]` into multiplicand A and `depvals[1]` into multiplier B;
  - latch `robid`, `wbs` and `flags`;
  - clear the accumulator and the 3-bit iteration counter;
  - go to COMPUTE.
- `input_transmit` outside IDLE is ignored; no queuing.
- COMPUTE, each edge:
  - if B[0], acc <= acc + A (mod 256);
  - A <= A << 1; B >= B >> 1; counter++.
  - After the 8th iteration, write acc to the result register and go to BROADCAST.
- Result = (depvals[0] × depvals[1]) mod 256, unsigned; overflow bits are discarded with no flag.
- BROADCAST: grant = !`cdb_transmit` && !`rob_transmit`.
  - With grant, `cdb_transmit_out` and `rob_transmit_out` are both 1, combinationally, in that cycle; the next edge returns the unit to IDLE.
  - Without grant, the strobes stay 0 and the unit stays in BROADCAST, holding all data.
- Data outputs are registered:
  - `cdb_val` = `value_out` = result register;
  - `cdb_id` = `robid_out` = latched robid;
  - `wbs_out` and `flags_out` = latched values.
  - Data outputs are valid whenever a strobe is high and hold until the next result is written.
- Strobes are never high outside BROADCAST.

## Timing
- Reset (async, any state, including mid-COMPUTE): state IDLE, all registers and outputs 0, `busy`=0; the in-flight instruction is dropped.
- Accept edge E0 → `busy`=1 after E0.
- Compute edges E1–E8; result visible after E8.
- Earliest broadcast cycle is between E8 and E9; IDLE after E9.
- Minimum occupancy: 9 cycles after acceptance. Each cycle of bus contention adds one cycle.
- A new instruction may be accepted at the first edge where the state is IDLE. The strobe cycle itself is not IDLE, so there is no back-to-back accept in that cycle.

## Test plan
- Reset, then issue `depvals`={5,10}, robid 1, wbs B1:
  - `busy`=1 next cycle;
  - strobes 9 cycles after accept with `value_out`=`cdb_val`=50, `cdb_id`=`robid_out`=1, `wbs_out`=B1;
  - `busy`=0 after.
- Sequential issues {7,8}→56, {25,10}→250, {1,1}→1, each issued after `busy` falls, with robids 2, 3, 4 tagged correctly.
- Overflow: {16,16}→0, {255,255}→1, {0,200}→0.
- Contention: hold `cdb_transmit`=1 for 3 cycles at BROADCAST → no strobe, data held; strobes in the cycle after release, then `busy`=0. Repeat with `rob_transmit`.
- Issue with `busy`=1 (pulse `input_transmit` mid-COMPUTE with other values) → ignored; the original result and robid are broadcast.
- Assert `rst` mid-COMPUTE → `busy` and strobes 0 immediately. A following issue of {3,4} yields 12.
